// File: rtl/instruction_fetch.sv
// Purpose : instruction fetch stage with a 64 x 32-bit loadable instruction memory,
//           branch redirect and a halt on the all-ones word.
// Latency : one cycle from pc to instruction/instructionPC. A taken branch costs one invalid cycle.
// Backpressure: stall holds pc and the presented instruction. A taken branch overrides stall.
//
// Ports:
//   clock, reset          main clock, asynchronous active-high reset
//   stall                 hold fetch state and outputs
//   branch / unconditionalBranch / zeroFlag / branchInstruction / branchPC
//                         redirect request from the controller
//   imemWriteEnable / imemWriteAddress / imemWriteData
//                         instruction memory load port (usable in any state)
//   instruction / instructionPC / instructionValid
//                         fetched word, its address, and its valid flag
//   pc                    address of the next fetch
//   halted                high only in HALT
module instruction_fetch (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch,
    input  logic        unconditionalBranch,
    input  logic        zeroFlag,
    input  logic [31:0] branchInstruction,
    input  logic [63:0] branchPC,
    input  logic        imemWriteEnable,
    input  logic [5:0]  imemWriteAddress,
    input  logic [31:0] imemWriteData,
    output logic [31:0] instruction,
    output logic [63:0] instructionPC,
    output logic        instructionValid,
    output logic [63:0] pc,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_REDIRECT,
        S_HALT
    } state_t;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] ipc_q, ipc_d;
    logic [31:0] instr_q, instr_d;
    logic        vld_q, vld_d;
    logic        halted_q, halted_d;

    logic [31:0] mem [64];
    logic [31:0] rd_word;
    logic        cond_taken;
    logic        taken;
    logic [63:0] uncond_off;
    logic [63:0] cond_off;
    logic [63:0] target;
    logic        unused_bits;

    // Asynchronous read: a write on the same edge is seen only by the next fetch.
    assign rd_word = mem[pc_q[7:2]];

    // Bit 24 distinguishes CBNZ (1) from CBZ (0).
    assign cond_taken = branch && (branchInstruction[24] ? !zeroFlag : zeroFlag);
    assign taken      = unconditionalBranch || cond_taken;
    assign uncond_off = {{36{branchInstruction[25]}}, branchInstruction[25:0], 2'b00};
    assign cond_off   = {{43{branchInstruction[23]}}, branchInstruction[23:5], 2'b00};
    assign target     = branchPC + (unconditionalBranch ? uncond_off : cond_off);

    assign unused_bits = &{1'b0, branchInstruction[31:26], branchInstruction[4:0]};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ipc_d    = ipc_q;
        instr_d  = instr_q;
        vld_d    = vld_q;
        halted_d = halted_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            // REDIRECT is the bubble after a taken branch. Leaving it performs
            // the fetch at the new pc, so only one invalid cycle is seen.
            S_FETCH, S_REDIRECT: begin
                if (taken) begin
                    pc_d    = target;
                    vld_d   = 1'b0;
                    state_d = S_REDIRECT;
                end else if (!stall) begin
                    if (rd_word == HALT_WORD) begin
                        vld_d    = 1'b0;
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        instr_d = rd_word;
                        ipc_d   = pc_q;
                        vld_d   = 1'b1;
                        pc_d    = pc_q + 64'd4;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= 64'd0;
            ipc_q    <= 64'd0;
            instr_q  <= 32'd0;
            vld_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ipc_q    <= ipc_d;
            instr_q  <= instr_d;
            vld_q    <= vld_d;
            halted_q <= halted_d;
        end
    end

    // Memory contents survive reset so a program can be loaded before release.
    always_ff @(posedge clock) begin
        if (imemWriteEnable) begin
            mem[imemWriteAddress] <= imemWriteData;
        end
    end

    assign instruction      = instr_q;
    assign instructionPC    = ipc_q;
    assign instructionValid = vld_q;
    assign pc               = pc_q;
    assign halted           = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Purpose : directed self-checking bench for instruction_fetch.
// Latency : expects the fetched word one cycle after its pc and one bubble per taken branch.
// Backpressure: exercises stall on its own, and stall together with a branch.
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch;
    logic        unconditionalBranch;
    logic        zeroFlag;
    logic [31:0] branchInstruction;
    logic [63:0] branchPC;
    logic        imemWriteEnable;
    logic [5:0]  imemWriteAddress;
    logic [31:0] imemWriteData;
    logic [31:0] instruction;
    logic [63:0] instructionPC;
    logic        instructionValid;
    logic [63:0] pc;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    instruction_fetch dut (
        .clock              (clock),
        .reset              (reset),
        .stall              (stall),
        .branch             (branch),
        .unconditionalBranch(unconditionalBranch),
        .zeroFlag           (zeroFlag),
        .branchInstruction  (branchInstruction),
        .branchPC           (branchPC),
        .imemWriteEnable    (imemWriteEnable),
        .imemWriteAddress   (imemWriteAddress),
        .imemWriteData      (imemWriteData),
        .instruction        (instruction),
        .instructionPC      (instructionPC),
        .instructionValid   (instructionValid),
        .pc                 (pc),
        .halted             (halted)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        stall = 1'b0; branch = 1'b0; unconditionalBranch = 1'b0; zeroFlag = 1'b0;
        branchInstruction = 32'd0; branchPC = 64'd0;
        imemWriteEnable = 1'b0; imemWriteAddress = 6'd0; imemWriteData = 32'd0;
        #1;
        checks++; if (pc !== 64'd0 || instructionValid !== 1'b0 || halted !== 1'b0) begin
            failures++; $display("FAIL reset_state pc=%h vld=%b halted=%b expected 0/0/0", pc, instructionValid, halted); end
        // Load a recognisable program while still in reset.
        for (int i = 0; i < 64; i++) begin
            imemWriteEnable  = 1'b1;
            imemWriteAddress = i[5:0];
            imemWriteData    = 32'hA000_0000 + i;
            tick();
        end
        imemWriteEnable = 1'b0;
        checks++; if (instruction !== 32'd0 || instructionPC !== 64'd0 || pc !== 64'd0) begin
            failures++; $display("FAIL reset_hold instr=%h ipc=%h pc=%h expected 0/0/0", instruction, instructionPC, pc); end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        tick(); // IDLE -> FETCH
        checks++; if (instructionValid !== 1'b0 || pc !== 64'd0) begin
            failures++; $display("FAIL idle_cycle vld=%b pc=%h expected 0/0", instructionValid, pc); end
        tick();
        checks++; if (instructionValid !== 1'b1 || instruction !== 32'hA000_0000 || instructionPC !== 64'd0 || pc !== 64'd4) begin
            failures++; $display("FAIL seq_a0 vld=%b instr=%h ipc=%h pc=%h expected 1/A0000000/0/4", instructionValid, instruction, instructionPC, pc); end
        tick();
        checks++; if (instructionValid !== 1'b1 || instruction !== 32'hA000_0001 || instructionPC !== 64'd4 || pc !== 64'd8) begin
            failures++; $display("FAIL seq_a1 vld=%b instr=%h ipc=%h pc=%h expected 1/A0000001/4/8", instructionValid, instruction, instructionPC, pc); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (instructionValid !== 1'b1 || instruction !== 32'hA000_0001 || pc !== 64'd8) begin
                failures++; $display("FAIL stall_hold%0d vld=%b instr=%h pc=%h expected 1/A0000001/8", i, instructionValid, instruction, pc); end
        end
        stall = 1'b0;
        tick();
        checks++; if (instructionValid !== 1'b1 || instruction !== 32'hA000_0002 || instructionPC !== 64'd8 || pc !== 64'hC) begin
            failures++; $display("FAIL stall_release vld=%b instr=%h ipc=%h pc=%h expected 1/A0000002/8/C", instructionValid, instruction, instructionPC, pc); end
    endtask

    task automatic test_uncond_branch();
        unconditionalBranch = 1'b1;
        branchPC            = 64'h10;
        branchInstruction   = {6'b000101, 26'h3FF_FFFE}; // offset -8
        tick();
        checks++; if (instructionValid !== 1'b0 || pc !== 64'h8) begin
            failures++; $display("FAIL ub_redirect vld=%b pc=%h expected 0/8", instructionValid, pc); end
        unconditionalBranch = 1'b0;
        tick();
        checks++; if (instructionValid !== 1'b1 || instruction !== 32'hA000_0002 || instructionPC !== 64'h8 || pc !== 64'hC) begin
            failures++; $display("FAIL ub_target vld=%b instr=%h ipc=%h pc=%h expected 1/A0000002/8/C", instructionValid, instruction, instructionPC, pc); end
    endtask

    task automatic test_cond_branch();
        // CBZ, imm19=3, zero set: taken to 0x20 + 12.
        branch = 1'b1; zeroFlag = 1'b1;
        branchInstruction = 32'hB400_0060; branchPC = 64'h20;
        tick();
        checks++; if (instructionValid !== 1'b0 || pc !== 64'h2C) begin
            failures++; $display("FAIL cbz_taken vld=%b pc=%h expected 0/2C", instructionValid, pc); end
        branch = 1'b0;
        tick();
        checks++; if (instructionValid !== 1'b1 || instruction !== 32'hA000_000B || instructionPC !== 64'h2C || pc !== 64'h30) begin
            failures++; $display("FAIL cbz_target vld=%b instr=%h ipc=%h pc=%h expected 1/A000000B/2C/30", instructionValid, instruction, instructionPC, pc); end
        // CBZ with zero clear: not taken, sequential.
        branch = 1'b1; zeroFlag = 1'b0;
        tick();
        checks++; if (instructionValid !== 1'b1 || instruction !== 32'hA000_000C || pc !== 64'h34) begin
            failures++; $display("FAIL cbz_not_taken vld=%b instr=%h pc=%h expected 1/A000000C/34", instructionValid, instruction, pc); end
        // CBNZ with zero clear: taken.
        branchInstruction = 32'hB500_0060;
        tick();
        checks++; if (instructionValid !== 1'b0 || pc !== 64'h2C) begin
            failures++; $display("FAIL cbnz_taken vld=%b pc=%h expected 0/2C", instructionValid, pc); end
        branch = 1'b0;
        tick();
        checks++; if (instruction !== 32'hA000_000B || pc !== 64'h30) begin
            failures++; $display("FAIL cbnz_target instr=%h pc=%h expected A000000B/30", instruction, pc); end
    endtask

    task automatic test_branch_over_stall();
        stall = 1'b1; unconditionalBranch = 1'b1;
        branchPC = 64'h0; branchInstruction = {6'b000101, 26'd1};
        tick();
        checks++; if (instructionValid !== 1'b0 || pc !== 64'h4) begin
            failures++; $display("FAIL bstall_redirect vld=%b pc=%h expected 0/4", instructionValid, pc); end
        unconditionalBranch = 1'b0;
        tick();
        checks++; if (instructionValid !== 1'b0 || pc !== 64'h4) begin
            failures++; $display("FAIL bstall_hold vld=%b pc=%h expected 0/4", instructionValid, pc); end
        stall = 1'b0;
        tick();
        checks++; if (instructionValid !== 1'b1 || instruction !== 32'hA000_0001 || instructionPC !== 64'h4 || pc !== 64'h8) begin
            failures++; $display("FAIL bstall_target vld=%b instr=%h ipc=%h pc=%h expected 1/A0000001/4/8", instructionValid, instruction, instructionPC, pc); end
    endtask

    task automatic test_write_during_fetch();
        imemWriteEnable = 1'b1; imemWriteAddress = 6'd2; imemWriteData = 32'h1234_5678;
        tick();
        imemWriteEnable = 1'b0;
        checks++; if (instruction !== 32'hA000_0002 || pc !== 64'hC) begin
            failures++; $display("FAIL wr_old_word instr=%h pc=%h expected A0000002/C", instruction, pc); end
        unconditionalBranch = 1'b1; branchPC = 64'h8; branchInstruction = 32'h1400_0000;
        tick();
        unconditionalBranch = 1'b0;
        tick();
        checks++; if (instructionValid !== 1'b1 || instruction !== 32'h1234_5678 || instructionPC !== 64'h8) begin
            failures++; $display("FAIL wr_new_word vld=%b instr=%h ipc=%h expected 1/12345678/8", instructionValid, instruction, instructionPC); end
    endtask

    task automatic test_halt();
        imemWriteEnable = 1'b1; imemWriteAddress = 6'd5; imemWriteData = 32'hFFFF_FFFF;
        unconditionalBranch = 1'b1; branchPC = 64'h10; branchInstruction = 32'h1400_0000;
        tick();
        imemWriteEnable = 1'b0; unconditionalBranch = 1'b0;
        tick();
        checks++; if (instructionValid !== 1'b1 || instruction !== 32'hA000_0004 || instructionPC !== 64'h10 || pc !== 64'h14) begin
            failures++; $display("FAIL halt_pre vld=%b instr=%h ipc=%h pc=%h expected 1/A0000004/10/14", instructionValid, instruction, instructionPC, pc); end
        tick();
        checks++; if (instructionValid !== 1'b0 || halted !== 1'b1 || pc !== 64'h14) begin
            failures++; $display("FAIL halt_enter vld=%b halted=%b pc=%h expected 0/1/14", instructionValid, halted, pc); end
        unconditionalBranch = 1'b1; stall = 1'b1; branchPC = 64'h0;
        tick();
        tick();
        unconditionalBranch = 1'b0; stall = 1'b0;
        checks++; if (instructionValid !== 1'b0 || halted !== 1'b1 || pc !== 64'h14) begin
            failures++; $display("FAIL halt_sticky vld=%b halted=%b pc=%h expected 0/1/14", instructionValid, halted, pc); end
    endtask

    task automatic test_async_reset();
        #3 reset = 1'b1;
        #1;
        checks++; if (pc !== 64'd0 || halted !== 1'b0 || instructionValid !== 1'b0 || instruction !== 32'd0 || instructionPC !== 64'd0) begin
            failures++; $display("FAIL areset_halt pc=%h halted=%b vld=%b instr=%h ipc=%h expected all 0", pc, halted, instructionValid, instruction, instructionPC); end
        @(posedge clock); #1 reset = 1'b0;
        tick();
        tick();
        checks++; if (instructionValid !== 1'b1 || instruction !== 32'hA000_0000 || pc !== 64'd4) begin
            failures++; $display("FAIL mem_retained vld=%b instr=%h pc=%h expected 1/A0000000/4", instructionValid, instruction, pc); end
        stall = 1'b1;
        tick();
        #3 reset = 1'b1;
        #1;
        checks++; if (pc !== 64'd0 || instructionValid !== 1'b0 || instruction !== 32'd0) begin
            failures++; $display("FAIL areset_stall pc=%h vld=%b instr=%h expected 0/0/0", pc, instructionValid, instruction); end
        stall = 1'b0;
        @(posedge clock); #1 reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_uncond_branch();
        test_cond_branch();
        test_branch_over_stall();
        test_write_during_fetch();
        test_halt();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL: one clock; reset is asynchronous and active-high.
REQ-002 SHALL: clock  in  1  main clock; all state changes on its rising edge.
REQ-003 SHALL: reset  in  1  async active-high; clears all state.
REQ-004 SHALL: stall  in  1  holds fetch state and outputs when 1.
REQ-005 SHALL: branch  in  1  conditional-branch flag from controller (CBZ/CBNZ).
REQ-006 SHALL: unconditionalBranch  in  1  B/BL flag from controller.
REQ-007 SHALL: zeroFlag  in  1  ALU zero result qualifying the conditional branch.
REQ-008 SHALL: branchInstruction  in  32  instruction word that raised the branch flags.
REQ-009 SHALL: branchPC  in  64  address of branchInstruction.
REQ-010 SHALL: imemWriteEnable  in  1  instruction-memory load strobe.
REQ-011 SHALL: imemWriteAddress  in  6  word index for load.
REQ-012 SHALL: imemWriteData  in  32  word to load.
REQ-013 SHALL: instruction  out  32  fetched word, to controller.
REQ-014 SHALL: instructionPC  out  64  address of instruction.
REQ-015 SHALL: instructionValid  out  1  instruction/instructionPC valid this cycle.
REQ-016 SHALL: pc  out  64  address of the next fetch.
REQ-017 SHALL: halted  out  1  block is in HALT.

Function
REQ-018 SHALL: contain a 64 x 32-bit instruction memory indexed by pc[7:2]; pc[63:8] ignored, so addresses wrap every 256 bytes.
REQ-019 SHALL: write imemWriteData to entry imemWriteAddress on a rising edge with imemWriteEnable=1, in any state; a same-cycle fetch of that entry returns the old word.
REQ-020 SHALL: implement states IDLE, FETCH, REDIRECT, HALT; IDLE -> FETCH unconditionally after one cycle.
REQ-021 SHALL: in FETCH with stall=0 and no taken branch: instruction <= mem[pc[7:2]], instructionPC <= pc, instructionValid <= 1, pc <= pc + 4 (64-bit, wraps modulo 2^64).
REQ-022 SHALL: hold pc, instruction, instructionPC, instructionValid unchanged while stall=1 and no taken branch.
REQ-023 SHALL: take a branch when unconditionalBranch=1, or branch=1 with (branchInstruction[24]=0 and zeroFlag=1) or (branchInstruction[24]=1 and zeroFlag=0).
REQ-024 SHALL: unconditional offset = sign-extend(branchInstruction[25:0]) << 2 to 64 bits; conditional offset = sign-extend(branchInstruction[23:5]) << 2.
REQ-025 SHALL: on a taken branch: pc <= branchPC + offset, instructionValid <= 0, state <= REDIRECT; unconditionalBranch wins if both flags set.
REQ-026 SHALL: give a taken branch priority over stall in FETCH and REDIRECT.
REQ-027 SHALL: REDIRECT last one cycle with instructionValid=0, then FETCH (or REDIRECT again on a new taken branch).
REQ-028 SHALL: if the word read in FETCH equals 32'hFFFFFFFF, not present it: instructionValid <= 0, pc unchanged, state <= HALT.
REQ-029 SHALL: HALT persists until reset; branch, stall inputs ignored; halted=1 only in HALT.
REQ-030 SHALL: ignore branch inputs in IDLE.

Reset
REQ-031 SHALL: on reset: pc=0, instruction=0, instructionPC=0, instructionValid=0, halted=0, state=IDLE; memory contents retained.
REQ-032 SHALL: reset asserted mid-operation (any state, including during stall or REDIRECT) take effect immediately, without waiting for a clock edge.

Verification
REQ-033 SHALL: load mem[0..3]=A0,A1,A2,A3, release reset -> instructionValid=1 with instruction=A0 at PC 0, then A1 at 4, A2 at 8; pc advances by 4 per cycle.
REQ-034 SHALL: stall=1 for 3 cycles after A1 presented -> instruction=A1, pc=8 held; A2 appears the cycle after stall drops.
REQ-035 SHALL: unconditionalBranch=1, branchPC=0x10, imm26=0x3FFFFFE -> pc=0x08, one invalid cycle, then mem[2] with instructionPC=0x08.
REQ-036 SHALL: branch=1, instr[24]=0, imm19=3, branchPC=0x20: zeroFlag=1 -> pc=0x2C; zeroFlag=0 -> sequential fetch continues.
REQ-037 SHALL: mem[5]=0xFFFFFFFF -> after word at 0x10, instructionValid=0, halted=1, pc=0x14 held; reset -> pc=0, halted=0.
REQ-038 SHALL: taken branch with stall=1 simultaneously -> redirect occurs; reset asserted between clock edges -> outputs zero immediately.
